// File: rtl/load_aligner.sv
// rtl/load_aligner.sv - byte/half/word load alignment stage feeding the shifter
// Splits word-crossing loads into two aligned reads and merges them little-endian.
module load_aligner (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [31:0] REQ_ADDR,
    input  logic [1:0]  REQ_SIZE,
    input  logic        REQ_SIGNED,
    output logic        MEM_RD,
    output logic [31:0] MEM_ADDR,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_DATA,
    output logic [31:0] SH_IN,
    output logic [4:0]  SH_SHFT,
    output logic [1:0]  SH_SEL,
    output logic        SH_ARITH,
    output logic        OUT_VALID,
    input  logic        OUT_READY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic        split_q;
    logic [31:0] lo_q;
    logic [31:0] hi_q;
    logic        mem_rd_q;
    logic [31:0] mem_addr_q;
    logic [31:0] sh_in_q;
    logic [1:0]  sh_sel_q;
    logic        out_valid_q;

    logic        req_split;
    logic [63:0] pair;
    logic [31:0] sh_in_d;
    logic [1:0]  sh_sel_d;

    function automatic logic [31:0] align_load(input logic [63:0] words,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size);
        logic [31:0] raw;
        raw = 32'(words >> {off, 3'b000});
        case (size)
            2'd0:    align_load = {24'b0, raw[7:0]};
            2'd1:    align_load = {16'b0, raw[15:0]};
            default: align_load = raw;
        endcase
    endfunction

    assign req_split = (REQ_SIZE[1] && REQ_ADDR[1:0] != 2'd0) ||
                       (REQ_SIZE == 2'd1 && REQ_ADDR[1:0] == 2'd3);

    // Result is formed from the word arriving this cycle so DONE outputs are
    // already registered and never follow MEM_DATA afterwards.
    assign pair    = (state_q == RD1) ? {MEM_DATA, lo_q} : {hi_q, MEM_DATA};
    assign sh_in_d = align_load(pair, off_q, size_q);

    always_comb begin
        sh_sel_d = 2'd0;
        if (signed_q && size_q == 2'd0) begin
            sh_sel_d = 2'd2;
        end else if (signed_q && size_q == 2'd1) begin
            sh_sel_d = 2'd3;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            off_q       <= 2'd0;
            size_q      <= 2'd0;
            signed_q    <= 1'b0;
            split_q     <= 1'b0;
            lo_q        <= 32'd0;
            hi_q        <= 32'd0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            sh_in_q     <= 32'd0;
            sh_sel_q    <= 2'd0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (REQ_VALID) begin
                        off_q      <= REQ_ADDR[1:0];
                        size_q     <= REQ_SIZE;
                        signed_q   <= REQ_SIGNED;
                        split_q    <= req_split;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= {REQ_ADDR[31:2], 2'b00};
                        state_q    <= RD0;
                    end
                end
                RD0: begin
                    if (MEM_ACK) begin
                        lo_q <= MEM_DATA;
                        if (split_q) begin
                            mem_addr_q <= mem_addr_q + 32'd4;
                            state_q    <= RD1;
                        end else begin
                            mem_rd_q    <= 1'b0;
                            sh_in_q     <= sh_in_d;
                            sh_sel_q    <= sh_sel_d;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                RD1: begin
                    if (MEM_ACK) begin
                        hi_q        <= MEM_DATA;
                        mem_rd_q    <= 1'b0;
                        sh_in_q     <= sh_in_d;
                        sh_sel_q    <= sh_sel_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign REQ_READY = (state_q == IDLE);
    assign MEM_RD    = mem_rd_q;
    assign MEM_ADDR  = mem_addr_q;
    assign SH_IN     = sh_in_q;
    assign SH_SEL    = sh_sel_q;
    assign SH_SHFT   = 5'd0;
    assign SH_ARITH  = 1'b0;
    assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_load_aligner.sv
// tb/tb_load_aligner.sv - table-driven scoreboard bench for load_aligner
module tb_load_aligner;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic [31:0] REQ_ADDR = 32'd0;
    logic [1:0]  REQ_SIZE = 2'd0;
    logic        REQ_SIGNED = 1'b0;
    logic        MEM_RD;
    logic [31:0] MEM_ADDR;
    logic        MEM_ACK = 1'b0;
    logic [31:0] MEM_DATA = 32'd0;
    logic [31:0] SH_IN;
    logic [4:0]  SH_SHFT;
    logic [1:0]  SH_SEL;
    logic        SH_ARITH;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;

    load_aligner dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR),
        .REQ_SIZE(REQ_SIZE), .REQ_SIGNED(REQ_SIGNED),
        .MEM_RD(MEM_RD), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK), .MEM_DATA(MEM_DATA),
        .SH_IN(SH_IN), .SH_SHFT(SH_SHFT), .SH_SEL(SH_SEL), .SH_ARITH(SH_ARITH),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] w0;
        logic [31:0] w1;
        int          nreads;
        int          waits;
        int          hold;
        logic [31:0] exp_in;
        logic [1:0]  exp_sel;
        logic [31:0] exp_res;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_in_q[$];
    logic [1:0]  exp_sel_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic logic [31:0] shifter(input logic [31:0] x, input logic [1:0] sel);
        case (sel)
            2'd2:    shifter = {{24{x[7]}}, x[7:0]};
            2'd3:    shifter = {{16{x[15]}}, x[15:0]};
            default: shifter = x;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_load(input vec_t v);
        int          cyc;
        logic [31:0] a0;
        logic [31:0] ea;
        logic [31:0] e_in;
        logic [1:0]  e_sel;
        check("req_ready_idle", {31'b0, REQ_READY}, 32'd1);
        REQ_VALID  = 1'b1;
        REQ_ADDR   = v.addr;
        REQ_SIZE   = v.size;
        REQ_SIGNED = v.sgn;
        exp_addr_q.push_back({v.addr[31:2], 2'b00});
        if (v.nreads == 2) exp_addr_q.push_back({v.addr[31:2], 2'b00} + 32'd4);
        exp_in_q.push_back(v.exp_in);
        exp_sel_q.push_back(v.exp_sel);
        tick();
        REQ_VALID = 1'b0;
        cyc = 1;
        check("req_ready_busy", {31'b0, REQ_READY}, 32'd0);
        for (int r = 0; r < v.nreads; r++) begin
            a0 = MEM_ADDR;
            for (int w = 0; w < v.waits; w++) begin
                check("rd_held", {31'b0, MEM_RD}, 32'd1);
                check("addr_held", MEM_ADDR, a0);
                tick();
                cyc++;
            end
            check("mem_rd", {31'b0, MEM_RD}, 32'd1);
            ea = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 32'hxxxxxxxx;
            check("mem_addr", MEM_ADDR, ea);
            MEM_ACK  = 1'b1;
            MEM_DATA = (r == 0) ? v.w0 : v.w1;
            tick();
            cyc++;
            MEM_ACK  = 1'b0;
            MEM_DATA = $urandom;
        end
        for (int k = 0; k < 20 && !OUT_VALID; k++) begin
            tick();
            cyc++;
        end
        check("out_valid", {31'b0, OUT_VALID}, 32'd1);
        check("latency", cyc, 1 + v.nreads * (1 + v.waits));
        check("no_extra_read", {31'b0, MEM_RD}, 32'd0);
        e_in  = exp_in_q.pop_front();
        e_sel = exp_sel_q.pop_front();
        check("sh_in", SH_IN, e_in);
        check("sh_sel", {30'b0, SH_SEL}, {30'b0, e_sel});
        check("result", shifter(SH_IN, SH_SEL), v.exp_res);
        check("sh_consts", {26'b0, SH_SHFT, SH_ARITH}, 32'd0);
        for (int h = 0; h < v.hold; h++) begin
            MEM_DATA = $urandom;
            MEM_ACK  = 1'($urandom_range(0, 1));
            tick();
            check("hold_valid", {31'b0, OUT_VALID}, 32'd1);
            check("hold_sh_in", SH_IN, e_in);
            check("hold_sh_sel", {30'b0, SH_SEL}, {30'b0, e_sel});
            check("hold_req_ready", {31'b0, REQ_READY}, 32'd0);
        end
        MEM_ACK   = 1'b0;
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        check("out_valid_clr", {31'b0, OUT_VALID}, 32'd0);
        check("req_ready_after", {31'b0, REQ_READY}, 32'd1);
    endtask

    initial begin
        //         addr          sz    s     w0            w1            nr wt hd exp_in        sel   exp_res
        vecs[0] = '{32'h00000100, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0,        1, 0, 0, 32'hDEADBEEF, 2'd0, 32'hDEADBEEF};
        vecs[1] = '{32'h00000203, 2'd0, 1'b1, 32'h80112233, 32'h0,        1, 0, 0, 32'h00000080, 2'd2, 32'hFFFFFF80};
        vecs[2] = '{32'h00000203, 2'd0, 1'b0, 32'h80112233, 32'h0,        1, 0, 0, 32'h00000080, 2'd0, 32'h00000080};
        vecs[3] = '{32'h00000307, 2'd1, 1'b1, 32'hAB000000, 32'h000000CD, 2, 0, 0, 32'h0000CDAB, 2'd3, 32'hFFFFCDAB};
        vecs[4] = '{32'hFFFFFFFE, 2'd2, 1'b0, 32'h11220000, 32'h00003344, 2, 3, 0, 32'h33441122, 2'd0, 32'h33441122};
        vecs[5] = '{32'h00000402, 2'd1, 1'b0, 32'h89AB1234, 32'h0,        1, 0, 0, 32'h000089AB, 2'd0, 32'h000089AB};
        vecs[6] = '{32'h00000501, 2'd3, 1'b1, 32'h44332211, 32'h88776655, 2, 1, 0, 32'h55443322, 2'd0, 32'h55443322};
        vecs[7] = '{32'h00000606, 2'd1, 1'b1, 32'h7FFF0000, 32'h0,        1, 0, 5, 32'h00007FFF, 2'd3, 32'h00007FFF};
        vecs[8] = '{32'h00000700, 2'd0, 1'b1, 32'h000000FF, 32'h0,        1, 2, 0, 32'h000000FF, 2'd2, 32'hFFFFFFFF};
        vecs[9] = '{32'h00000802, 2'd0, 1'b1, 32'h12345678, 32'h0,        1, 0, 0, 32'h00000034, 2'd2, 32'h00000034};

        #12;
        check("rst_req_ready", {31'b0, REQ_READY}, 32'd1);
        check("rst_mem", {31'b0, MEM_RD, OUT_VALID}, 32'd0);
        check("rst_mem_addr", MEM_ADDR, 32'd0);
        check("rst_sh", {SH_IN[23:0], SH_SHFT, SH_SEL, SH_ARITH}, 32'd0);
        check("rst_sh_in", SH_IN, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_load(vecs[i]);
        end

        // Reset while the second read of a split load is outstanding.
        REQ_VALID  = 1'b1;
        REQ_ADDR   = 32'h00000307;
        REQ_SIZE   = 2'd1;
        REQ_SIGNED = 1'b1;
        tick();
        REQ_VALID = 1'b0;
        MEM_ACK   = 1'b1;
        MEM_DATA  = 32'hAB000000;
        tick();
        MEM_ACK = 1'b0;
        tick();
        check("rd1_pending", {31'b0, MEM_RD}, 32'd1);
        check("rd1_addr", MEM_ADDR, 32'h00000308);
        #2;
        RST = 1'b1;
        #1;
        check("async_rst_mem_rd", {31'b0, MEM_RD}, 32'd0);
        check("async_rst_outs", {SH_IN[23:0], SH_SHFT, SH_SEL, SH_ARITH}, 32'd0);
        check("async_rst_valid", {30'b0, OUT_VALID, REQ_READY}, 32'd1);
        check("async_rst_addr", MEM_ADDR, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        tick();
        run_load(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
